// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit data-memory initiator.
//               Provides op_type codes, FSM state codes, exception codes, the
//               latched-op record and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // op_type encodings presented by the MEM stage
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  // Initiator FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Exception codes reported alongside done
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // Fields of the accepted op that are still needed once the bus returns data
  typedef struct packed {
    logic [2:0] op_type;
    logic [1:0] lane;
  } lsu_op_t;

  // Stores occupy the top three encodings
  function automatic logic is_store(input logic [2:0] op_type);
    return (op_type == OP_SW) || (op_type == OP_SH) || (op_type == OP_SB);
  endfunction

  // Natural-alignment check: words need addr[1:0]==0, halves need addr[0]==0
  function automatic logic is_misaligned(input logic [2:0] op_type, input logic [1:0] low);
    logic bad;
    bad = 1'b0;
    case (op_type)
      OP_LW, OP_SW:         bad = (low != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = low[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load-data extractor. Selects the byte or half
//               addressed by the low address bits out of a memory word and
//               sign- or zero-extends it according to the load type.
// Ports       : word    in  32  raw word returned by data memory
//               lane    in  2   byte address bits [1:0] of the access
//               op_type in  3   load type (LW/LH/LHU/LB/LBU)
//               data    out 32  extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  op_type,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? word[31:16] : word[15:0];
    case (op_type)
      OP_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  data = {24'h000000, sel_byte};
      OP_LH:   data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  data = {16'h0000, sel_half};
      default: data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_initiator
// Description : Initiator side of the data-memory port. Accepts one load or
//               store from the MEM stage, checks alignment and range, issues
//               a single req/ready transaction with word address, byte enables
//               and lane-replicated write data, and returns the extended load
//               result or an AdEL/AdES/DBE exception with a one-cycle done.
// Ports       : clk, clr_n (async active-low reset)
//               op_valid/op_type/op_addr/op_wdata  - access from MEM stage
//               stall, done, ld_data, exc_valid, exc_code - back to pipeline
//               mem_req/mem_we/mem_be/mem_addr/mem_wdata   - to data memory
//               mem_ready/mem_rdata                        - from data memory
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int DM_WORDS    = 4096,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int               CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  // 33 bits so a full 4 GiB memory does not wrap the limit to zero
  localparam logic [32:0]      ADDR_LIMIT = 33'(DM_WORDS) * 33'd4;

  state_t           state;
  lsu_op_t          held_op;
  logic [CNT_W-1:0] tmo_cnt;

  logic             req_fault;
  logic [4:0]       fault_code;
  logic [3:0]       fmt_be;
  logic [31:0]      fmt_wdata;
  logic [31:0]      aligned_data;

  // Released with reset as well so the pipeline is never frozen while
  // the initiator is held in reset.
  assign stall = clr_n & op_valid & (state != ST_DONE);

  // ---------------------------------------------------------------------
  // Fault check and store formatting on the incoming op
  // ---------------------------------------------------------------------
  always_comb begin
    req_fault  = is_misaligned(op_type, op_addr[1:0]) ||
                 ({1'b0, op_addr} >= ADDR_LIMIT);
    fault_code = is_store(op_type) ? EXC_ADES : EXC_ADEL;
  end

  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = 32'h0000_0000;
    case (op_type)
      OP_SW: begin
        fmt_be    = 4'b1111;
        fmt_wdata = op_wdata;
      end
      OP_SH: begin
        fmt_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{op_wdata[15:0]}};
      end
      OP_SB: begin
        fmt_be    = 4'b0001 << op_addr[1:0];
        fmt_wdata = {4{op_wdata[7:0]}};
      end
      default: begin
        fmt_be    = 4'b1111;
        fmt_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Extraction runs on the latched lane/type since op_* may change once
  // stall falls in the done cycle.
  lsu_load_align u_load_align (
    .word    (mem_rdata),
    .lane    (held_op.lane),
    .op_type (held_op.op_type),
    .data    (aligned_data)
  );

  // ---------------------------------------------------------------------
  // Control FSM and request registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= ST_IDLE;
      held_op   <= '0;
      tmo_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      done      <= 1'b0;
      ld_data   <= 32'h0000_0000;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
    end else begin
      // Result outputs are only meaningful during the single done cycle
      done      <= 1'b0;
      ld_data   <= 32'h0000_0000;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;

      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            held_op.op_type <= op_type;
            held_op.lane    <= op_addr[1:0];
            if (req_fault) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              exc_valid <= 1'b1;
              exc_code  <= fault_code;
            end else begin
              state     <= ST_BUSY;
              tmo_cnt   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store(op_type);
              mem_be    <= fmt_be;
              mem_addr  <= {op_addr[31:2], 2'b00};
              mem_wdata <= fmt_wdata;
            end
          end
        end

        ST_BUSY: begin
          if (mem_ready) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!is_store(held_op.op_type)) begin
              ld_data <= aligned_data;
            end
          end else if (tmo_cnt == CNT_LAST) begin
            state     <= ST_DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            exc_valid <= 1'b1;
            exc_code  <= EXC_DBE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_ONE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_initiator
// Description : Self-checking bench for lsu_mem_initiator. The bench plays
//               the data memory and predicts every result from the access
//               rules using plain arithmetic on a word-array memory image.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_mem_initiator;

  localparam int DM_WORDS    = 4096;
  localparam int TIMEOUT_CYC = 16;
  localparam int NEVER       = 1000;   // ready delay that never arrives

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_type = 3'd0;
  logic [31:0] op_addr = 32'h0;
  logic [31:0] op_wdata = 32'h0;
  logic        stall, done, exc_valid, mem_req, mem_we;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic [4:0]  exc_code;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_image [0:63];

  always #5 clk = ~clk;

  lsu_mem_initiator #(.DM_WORDS(DM_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .clr_n(clr_n),
    .op_valid(op_valid), .op_type(op_type), .op_addr(op_addr), .op_wdata(op_wdata),
    .stall(stall), .done(done), .ld_data(ld_data), .exc_valid(exc_valid), .exc_code(exc_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic logic [4:0] m_exc(input logic [2:0] t, input logic [31:0] a);
    longint unsigned ua;
    bit mis;
    ua  = a;
    mis = ((t == 0 || t == 5) && (a % 4) != 0) ||
          ((t == 1 || t == 2 || t == 6) && (a % 2) != 0);
    if (mis || ua >= longint'(DM_WORDS) * 4) return (t >= 5) ? 5'd5 : 5'd4;
    return 5'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
    if (t == 6) return ((a / 2) % 2 == 1) ? 4'b1100 : 4'b0011;
    if (t == 7) return 4'(1 << (a % 4));
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] wd);
    if (t == 6) return (wd & 32'hFFFF) * 32'h0001_0001;
    if (t == 7) return (wd & 32'hFF) * 32'h0101_0101;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    case (t)
      3, 4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (t == 3 && v >= 128) v = v | 32'hFFFF_FF00;
      end
      1, 2: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (t == 1 && v >= 32768) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // ---------------- driver / memory responder ----------------
  // Presents one op, answers the bus after 'delay' BUSY cycles, and records
  // what the DUT showed. Comparisons are done by the calling test.
  task automatic run_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input int delay, output int lat, output int req_cyc,
                        output logic [31:0] c_addr, output logic [3:0] c_be, output logic c_we,
                        output logic [31:0] c_wdata, output logic [31:0] got_ld,
                        output logic got_ev, output logic [4:0] got_code, output int stall_err);
    int wait_cnt;
    bit seen;
    logic [3:0]  be;
    logic [31:0] wv;
    op_valid = 1'b1; op_type = t; op_addr = a; op_wdata = wd; mem_ready = 1'b0;
    lat = 0; req_cyc = 0; stall_err = 0; seen = 0; wait_cnt = 0;
    c_addr = '0; c_be = '0; c_we = 1'b0; c_wdata = '0; got_ld = '0; got_ev = 1'b0; got_code = '0;
    #1;
    if (stall !== 1'b1) stall_err++;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (done === 1'b1) begin
        lat = k; got_ld = ld_data; got_ev = exc_valid; got_code = exc_code;
        if (stall !== 1'b0 || mem_req !== 1'b0) stall_err++;
        break;
      end
      if (stall !== 1'b1) stall_err++;
      if (mem_req === 1'b1) begin
        if (!seen) begin
          c_addr = mem_addr; c_be = mem_be; c_we = mem_we; c_wdata = mem_wdata; seen = 1;
        end
        req_cyc++;
        if (wait_cnt == delay) begin
          mem_ready = 1'b1;
          if (t >= 5) begin
            be = m_be(t, a);
            wv = m_wdata(t, wd);
            for (int i = 0; i < 4; i++)
              if (be[i]) mem_image[a[7:2]][8*i +: 8] = wv[8*i +: 8];
          end else begin
            mem_rdata = mem_image[a[7:2]];
          end
        end
        wait_cnt++;
      end
    end
    op_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  int lat, rq, serr;
  logic [31:0] ca, cwd, gld;
  logic [3:0]  cbe;
  logic        cwe, gev;
  logic [4:0]  gcode;

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, done, ld_data, exc_valid, exc_code} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b we=%b be=%b addr=%h wd=%h done=%b ld=%h ev=%b code=%0d, required all zero",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, done, ld_data, exc_valid, exc_code);
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b required 0", stall); end
    clr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    mem_image[4] = 32'hDEAD_BEEF;
    run_op(3'd0, 32'h10, 32'h0, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (ca !== 32'h10 || cbe !== 4'b1111 || cwe !== 1'b0) begin
      failures++; $display("FAIL lw_request: addr=%h be=%b we=%b required 00000010/1111/0", ca, cbe, cwe);
    end
    checks++;
    if (lat !== 2 || gld !== 32'hDEAD_BEEF || gev !== 1'b0 || serr !== 0) begin
      failures++; $display("FAIL lw_result: lat=%0d ld=%h ev=%b serr=%0d required 2/deadbeef/0/0", lat, gld, gev, serr);
    end
    mem_image[4] = 32'h8011_2233;
    run_op(3'd3, 32'h13, 32'h0, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (gld !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sign: got %h required ffffff80", gld); end
    run_op(3'd4, 32'h13, 32'h0, 1, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (gld !== 32'h0000_0080 || lat !== 3) begin failures++; $display("FAIL lbu_zero: got %h lat=%0d required 00000080 lat=3", gld, lat); end
    run_op(3'd1, 32'h12, 32'h0, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (gld !== 32'hFFFF_8011) begin failures++; $display("FAIL lh_sign: got %h required ffff8011", gld); end
    run_op(3'd2, 32'h10, 32'h0, 2, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (gld !== 32'h0000_2233) begin failures++; $display("FAIL lhu_zero: got %h required 00002233", gld); end
  endtask

  task automatic test_stores();
    run_op(3'd7, 32'h21, 32'h0000_00A5, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (cbe !== 4'b0010 || cwd !== 32'hA5A5_A5A5 || cwe !== 1'b1 || ca !== 32'h20 || gld !== 32'h0) begin
      failures++; $display("FAIL sb_format: be=%b wd=%h we=%b addr=%h ld=%h required 0010/a5a5a5a5/1/20/0", cbe, cwd, cwe, ca, gld);
    end
    run_op(3'd6, 32'h22, 32'h0000_1234, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (cbe !== 4'b1100 || cwd !== 32'h1234_1234 || cwe !== 1'b1) begin
      failures++; $display("FAIL sh_format: be=%b wd=%h we=%b required 1100/12341234/1", cbe, cwd, cwe);
    end
  endtask

  task automatic test_faults();
    run_op(3'd0, 32'h102, 32'h0, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (rq !== 0 || lat !== 1 || gev !== 1'b1 || gcode !== 5'd4 || serr !== 0) begin
      failures++; $display("FAIL lw_misaligned: req=%0d lat=%0d ev=%b code=%0d serr=%0d required 0/1/1/4/0", rq, lat, gev, gcode, serr);
    end
    run_op(3'd6, 32'h101, 32'h0, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (rq !== 0 || gcode !== 5'd5 || gev !== 1'b1) begin
      failures++; $display("FAIL sh_misaligned: req=%0d code=%0d ev=%b required 0/5/1", rq, gcode, gev);
    end
    run_op(3'd5, 32'h4000, 32'h0, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (rq !== 0 || gcode !== 5'd5 || lat !== 1) begin
      failures++; $display("FAIL sw_out_of_range: req=%0d code=%0d lat=%0d required 0/5/1", rq, gcode, lat);
    end
    run_op(3'd0, 32'h3FFC, 32'h0, 0, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (rq !== 1 || gev !== 1'b0 || lat !== 2 || gld !== mem_image[63]) begin
      failures++; $display("FAIL lw_last_word: req=%0d ev=%b lat=%0d ld=%h required 1/0/2/%h", rq, gev, lat, gld, mem_image[63]);
    end
  endtask

  task automatic test_timeout();
    run_op(3'd0, 32'h30, 32'h0, NEVER, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (rq !== TIMEOUT_CYC || lat !== TIMEOUT_CYC + 1 || gcode !== 5'd7 || gev !== 1'b1 || gld !== 32'h0 || serr !== 0) begin
      failures++; $display("FAIL timeout: req=%0d lat=%0d code=%0d ev=%b ld=%h serr=%0d required %0d/%0d/7/1/0/0",
                           rq, lat, gcode, gev, gld, serr, TIMEOUT_CYC, TIMEOUT_CYC + 1);
    end
    mem_image[12] = 32'h0BAD_F00D;
    run_op(3'd0, 32'h30, 32'h0, TIMEOUT_CYC - 1, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (gev !== 1'b0 || gld !== 32'h0BAD_F00D || lat !== TIMEOUT_CYC + 1) begin
      failures++; $display("FAIL ready_last_cycle: ev=%b ld=%h lat=%0d required 0/0badf00d/%0d", gev, gld, lat, TIMEOUT_CYC + 1);
    end
  endtask

  task automatic test_ready_outside_busy();
    int bad;
    bad = 0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || mem_req !== 1'b0) bad++;
    end
    mem_ready = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL idle_ready_ignored: %0d bad cycles required 0", bad); end
  endtask

  task automatic test_async_reset();
    op_valid = 1'b1; op_type = 3'd5; op_addr = 32'h44; op_wdata = 32'h1111_2222;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL busy_before_reset: req=%b required 1", mem_req); end
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL async_reset: req=%b stall=%b required 0/0", mem_req, stall);
    end
    op_valid = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
    mem_image[4] = 32'hCAFE_0001;
    run_op(3'd0, 32'h10, 32'h0, 1, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
    checks++;
    if (gld !== 32'hCAFE_0001 || lat !== 3 || gev !== 1'b0) begin
      failures++; $display("FAIL after_reset_lw: ld=%h lat=%0d ev=%b required cafe0001/3/0", gld, lat, gev);
    end
  endtask

  task automatic test_random();
    logic [2:0]  t;
    logic [31:0] a, wd, exp_ld;
    logic [4:0]  ecode;
    int          d, sel;
    for (int n = 0; n < 60; n++) begin
      t   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 19);
      if (sel < 14)      a = $urandom_range(0, 255);
      else if (sel < 17) a = 32'h3FF0 + $urandom_range(0, 15);
      else               a = 32'h4000 + $urandom_range(0, 4095);
      wd = $urandom;
      d  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
      ecode  = m_exc(t, a);
      exp_ld = (t < 5) ? m_load(t, a, mem_image[a[7:2]]) : 32'h0;
      run_op(t, a, wd, d, lat, rq, ca, cbe, cwe, cwd, gld, gev, gcode, serr);
      checks++;
      if (ecode != 0) begin
        if (lat !== 1 || rq !== 0 || gev !== 1'b1 || gcode !== ecode || gld !== 32'h0 || serr !== 0) begin
          failures++; $display("FAIL rnd_fault[%0d] t=%0d a=%h: lat=%0d req=%0d ev=%b code=%0d ld=%h serr=%0d required 1/0/1/%0d/0/0",
                               n, t, a, lat, rq, gev, gcode, gld, serr, ecode);
        end
      end else if (d >= TIMEOUT_CYC) begin
        if (lat !== TIMEOUT_CYC + 1 || rq !== TIMEOUT_CYC || gev !== 1'b1 || gcode !== 5'd7 || serr !== 0) begin
          failures++; $display("FAIL rnd_timeout[%0d] t=%0d a=%h: lat=%0d req=%0d ev=%b code=%0d required %0d/%0d/1/7",
                               n, t, a, lat, rq, gev, gcode, TIMEOUT_CYC + 1, TIMEOUT_CYC);
        end
      end else begin
        if (lat !== d + 2 || rq !== d + 1 || gev !== 1'b0 || gcode !== 5'd0 || gld !== exp_ld || serr !== 0 ||
            ca !== (a & 32'hFFFF_FFFC) || cbe !== m_be(t, a) || cwe !== (t >= 5) ||
            (t >= 5 && cwd !== m_wdata(t, wd))) begin
          failures++; $display("FAIL rnd_access[%0d] t=%0d a=%h: lat=%0d req=%0d ev=%b ld=%h addr=%h be=%b we=%b wd=%h serr=%0d required %0d/%0d/0/%h/%h/%b/%b/%h",
                               n, t, a, lat, rq, gev, gld, ca, cbe, cwe, cwd, serr,
                               d + 2, d + 1, exp_ld, a & 32'hFFFF_FFFC, m_be(t, a), (t >= 5), m_wdata(t, wd));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_image[i] = $urandom;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_ready_outside_busy();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
